// File: rtl/br_lite_ni.sv
// BrLite local-port network interface: PE-side TX injector and RX receive FIFO.
// Optional per-direction traffic counters are enabled by defining BRLITE_NI_STATS_EN.

package br_lite_pkg;
    localparam int BR_PAYLOAD_WIDTH = 32;
    localparam int BR_ID_WIDTH      = 5;

    typedef enum logic [1:0] {
        BR_SVC_ALL   = 2'd0,
        BR_SVC_TGT   = 2'd1,
        BR_SVC_CLEAR = 2'd2,
        BR_SVC_MON   = 2'd3
    } br_svc_t;

    typedef struct packed {
        logic [BR_ID_WIDTH-1:0]      id;
        logic [15:0]                 source;
        logic [15:0]                 target;
        br_svc_t                     service;
        logic [BR_PAYLOAD_WIDTH-1:0] payload;
    } br_data_t;
endpackage

module br_lite_ni
    import br_lite_pkg::*;
#(
    parameter logic [15:0] ADDRESS  = 16'h0000,
    parameter int          RX_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    input  logic [15:0]                 tx_target_i,
    input  br_svc_t                     tx_service_i,
    input  logic [BR_PAYLOAD_WIDTH-1:0] tx_payload_i,
    output logic                        tx_error_o,
    output br_data_t                    br_flit_o,
    output logic                        br_req_o,
    input  logic                        br_ack_i,
    input  logic                        br_busy_i,
    input  br_data_t                    br_flit_i,
    input  logic                        br_req_i,
    output logic                        br_ack_o,
    output logic                        rx_valid_o,
    output br_data_t                    rx_data_o,
    input  logic                        rx_ready_i
`ifdef BRLITE_NI_STATS_EN
    ,
    output logic [31:0]                 tx_count_o,
    output logic [31:0]                 rx_count_o
`endif
);

    localparam int PTR_W = $clog2(RX_DEPTH);

    // ---------------- transmit side ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_RELEASE} tx_state_t;

    tx_state_t              tx_state_reg, tx_state_next;
    br_data_t               flit_reg;
    logic [BR_ID_WIDTH-1:0] id_reg;
    logic                   tx_accept;
    logic                   tx_ready;
    logic                   tx_error;
    logic                   tx_legal;

    assign tx_legal = (tx_service_i == BR_SVC_ALL) || (tx_service_i == BR_SVC_TGT);

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_accept     = 1'b0;
        tx_ready      = 1'b0;
        tx_error      = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                // Gated by rst_ni so a request held during reset is never reported as consumed.
                if (rst_ni && tx_valid_i && !br_busy_i) begin
                    tx_ready = 1'b1;
                    if (tx_legal) begin
                        tx_accept     = 1'b1;
                        tx_state_next = TX_REQ;
                    end else begin
                        tx_error = 1'b1;
                    end
                end
            end
            TX_REQ: begin
                if (br_ack_i) tx_state_next = TX_RELEASE;
            end
            TX_RELEASE: begin
                if (!br_ack_i) tx_state_next = TX_IDLE;
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_state_reg <= TX_IDLE;
            flit_reg     <= '0;
            id_reg       <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            if (tx_accept) begin
                flit_reg.id      <= id_reg;
                flit_reg.source  <= ADDRESS;
                flit_reg.target  <= (tx_service_i == BR_SVC_ALL) ? 16'h0000 : tx_target_i;
                flit_reg.service <= tx_service_i;
                flit_reg.payload <= tx_payload_i;
                id_reg           <= id_reg + 1'b1;
            end
        end
    end

    assign tx_ready_o = tx_ready;
    assign tx_error_o = tx_error;
    assign br_flit_o  = flit_reg;
    assign br_req_o   = (tx_state_reg == TX_REQ);

    // ---------------- receive side ----------------
    typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;

    rx_state_t        rx_state_reg, rx_state_next;
    br_data_t         mem [RX_DEPTH];
    logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg;
    logic             fifo_full, fifo_empty;
    logic             push, pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign pop        = rx_ready_i && !fifo_empty;

    always_comb begin
        rx_state_next = rx_state_reg;
        push          = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (br_req_i && !fifo_full) begin
                    push          = 1'b1;
                    rx_state_next = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!br_req_i) rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_state_reg <= RX_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) mem[wr_ptr_reg[PTR_W-1:0]] <= br_flit_i;
    end

    assign br_ack_o   = (rx_state_reg == RX_ACK);
    assign rx_valid_o = !fifo_empty;
    assign rx_data_o  = mem[rd_ptr_reg[PTR_W-1:0]];

`ifdef BRLITE_NI_STATS_EN
    logic [31:0] tx_count_reg, rx_count_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_count_reg <= '0;
            rx_count_reg <= '0;
        end else begin
            if (tx_state_reg == TX_REQ && br_ack_i) tx_count_reg <= tx_count_reg + 1'b1;
            if (push)                               rx_count_reg <= rx_count_reg + 1'b1;
        end
    end

    assign tx_count_o = tx_count_reg;
    assign rx_count_o = rx_count_reg;
`endif

endmodule
